// File: rtl/bank_read_sched.sv
// Read-port scheduler for the shared banked scratchpad: picks one of three requesters per cycle
// and steers each returning read-valid back to its issuer through a fixed-latency tag pipeline.
`timescale 1ns/1ps

module bank_read_sched #(
    parameter int BANKBITS = 5,
    parameter int WORDBITS = 10,
    parameter int DATABITS = 32,
    parameter int RDLAT    = 2,
    parameter int STARVE   = 4
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         i_req,
    input  logic [BANKBITS+WORDBITS-1:0] i_addr,
    output logic                         i_gnt,
    output logic                         i_rvalid,

    input  logic                         d_req,
    input  logic [BANKBITS+WORDBITS-1:0] d_addr,
    output logic                         d_gnt,
    output logic                         d_rvalid,

    input  logic                         c_req,
    input  logic [BANKBITS+WORDBITS-1:0] c_addr,
    output logic                         c_gnt,
    output logic                         c_rvalid,

    input  logic                         m_rdy,
    output logic                         m_en,
    output logic [BANKBITS+WORDBITS-1:0] m_addr,
    input  logic [DATABITS-1:0]          m_rdata,
    output logic [DATABITS-1:0]          o_rdata
);

    localparam int AW = BANKBITS + WORDBITS;
    localparam logic [3:0] STARVE_CNT = 4'(STARVE);

    typedef enum logic [1:0] {
        REQ_I = 2'd0,
        REQ_D = 2'd1,
        REQ_C = 2'd2
    } req_code_t;

    logic [2:0]           w_req;
    logic [2:0]           w_starved;
    logic [2:0]           w_cand;
    logic [2:0]           w_gnt;
    req_code_t            w_code;
    logic [AW-1:0]        w_addr;

    logic [3:0]           r_wcnt [3];
    logic [AW-1:0]        r_mAddr;
    logic [RDLAT-1:0]     r_tagValid;
    logic [1:0]           r_tagCode [RDLAT];

    assign w_req = {c_req, d_req, i_req};

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_starved[k] = w_req[k] && (r_wcnt[k] == STARVE_CNT);
        end
    end

    // Starved requesters preempt the normal order; within either set the order is i > d > c.
    assign w_cand = (|w_starved) ? w_starved : w_req;

    always_comb begin
        w_gnt  = 3'b000;
        w_code = REQ_I;
        w_addr = r_mAddr;
        if (m_rdy && !rst) begin
            if (w_cand[0]) begin
                w_gnt  = 3'b001;
                w_code = REQ_I;
                w_addr = i_addr;
            end else if (w_cand[1]) begin
                w_gnt  = 3'b010;
                w_code = REQ_D;
                w_addr = d_addr;
            end else if (w_cand[2]) begin
                w_gnt  = 3'b100;
                w_code = REQ_C;
                w_addr = c_addr;
            end
        end
    end

    assign i_gnt  = w_gnt[0];
    assign d_gnt  = w_gnt[1];
    assign c_gnt  = w_gnt[2];
    assign m_en   = |w_gnt;
    assign m_addr = rst ? '0 : w_addr;

    // Wait counters keep counting through memory backpressure so a stalled requester still ages.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst || w_gnt[k] || !w_req[k]) begin
                r_wcnt[k] <= 4'd0;
            end else if (r_wcnt[k] != STARVE_CNT) begin
                r_wcnt[k] <= r_wcnt[k] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mAddr <= '0;
        end else if (m_en) begin
            r_mAddr <= w_addr;
        end
    end

    // The tag pipeline never stalls: memory returns data a fixed RDLAT cycles after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RDLAT; k++) begin
                r_tagValid[k] <= 1'b0;
                r_tagCode[k]  <= REQ_I;
            end
        end else begin
            r_tagValid[0] <= m_en;
            r_tagCode[0]  <= w_code;
            for (int k = 1; k < RDLAT; k++) begin
                r_tagValid[k] <= r_tagValid[k-1];
                r_tagCode[k]  <= r_tagCode[k-1];
            end
        end
    end

    assign i_rvalid = !rst && r_tagValid[RDLAT-1] && (r_tagCode[RDLAT-1] == REQ_I);
    assign d_rvalid = !rst && r_tagValid[RDLAT-1] && (r_tagCode[RDLAT-1] == REQ_D);
    assign c_rvalid = !rst && r_tagValid[RDLAT-1] && (r_tagCode[RDLAT-1] == REQ_C);

    assign o_rdata = m_rdata;

endmodule

// File: tb/tb_bank_read_sched.sv
// Self-checking bench for bank_read_sched: hand-computed vector table, directed corner sequences,
// and randomized traffic compared against a queue-based reference model.
`timescale 1ns/1ps

module tb_bank_read_sched;

    localparam int AW     = 15;
    localparam int DW     = 32;
    localparam int RDLAT  = 2;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, c_req;
    logic [AW-1:0] i_addr, d_addr, c_addr;
    logic          i_gnt, d_gnt, c_gnt;
    logic          i_rvalid, d_rvalid, c_rvalid;
    logic          m_rdy;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] o_rdata;

    always #5 clk = ~clk;

    bank_read_sched dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .c_req    (c_req),
        .c_addr   (c_addr),
        .c_gnt    (c_gnt),
        .c_rvalid (c_rvalid),
        .m_rdy    (m_rdy),
        .m_en     (m_en),
        .m_addr   (m_addr),
        .m_rdata  (m_rdata),
        .o_rdata  (o_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: outstanding reads as {cycle the data returns, requester}.
    typedef struct {
        int due;
        int code;
    } flight_t;

    flight_t       pend[$];
    int            wcnt[3];
    logic [AW-1:0] lastAddr;

    logic [2:0] obsGnt;
    logic [2:0] obsRv;
    assign obsGnt = {c_gnt, d_gnt, i_gnt};
    assign obsRv  = {c_rvalid, d_rvalid, i_rvalid};

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic       rdy;
        logic [2:0] gnt;
        logic [2:0] rv;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one cycle of inputs, compares against the model, then advances the model.
    task automatic applyStimulus(input logic rstV, input logic [2:0] req, input logic rdy,
                                 input logic [AW-1:0] aI, input logic [AW-1:0] aD,
                                 input logic [AW-1:0] aC, input logic [DW-1:0] rdata);
        int            g;
        int            rv;
        logic [AW-1:0] addr [3];
        logic [AW-1:0] expAddr;
        @(negedge clk);
        rst     = rstV;
        i_req   = req[0];
        d_req   = req[1];
        c_req   = req[2];
        i_addr  = aI;
        d_addr  = aD;
        c_addr  = aC;
        m_rdy   = rdy;
        m_rdata = rdata;
        #1;
        addr[0] = aI;
        addr[1] = aD;
        addr[2] = aC;
        g = -1;
        if (!rstV && rdy) begin
            for (int k = 0; k < 3; k++) if (g < 0 && req[k] && wcnt[k] >= STARVE) g = k;
            for (int k = 0; k < 3; k++) if (g < 0 && req[k]) g = k;
        end
        rv = -1;
        if (!rstV && pend.size() > 0 && pend[0].due == cyc) rv = pend[0].code;
        expAddr = rstV ? '0 : ((g >= 0) ? addr[g] : lastAddr);
        checkOutput("grant", 32'(obsGnt), (g >= 0) ? (32'(1) << g) : 32'(0));
        checkOutput("m_en", 32'(m_en), 32'(g >= 0));
        checkOutput("m_addr", 32'(m_addr), 32'(expAddr));
        checkOutput("rvalid", 32'(obsRv), (rv >= 0) ? (32'(1) << rv) : 32'(0));
        checkOutput("o_rdata", o_rdata, rdata);
        if (rstV) begin
            pend.delete();
            for (int k = 0; k < 3; k++) wcnt[k] = 0;
            lastAddr = '0;
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
            if (g >= 0) begin
                pend.push_back('{cyc + RDLAT, g});
                lastAddr = addr[g];
            end
            for (int k = 0; k < 3; k++) begin
                if (req[k] && k != g) wcnt[k] = (wcnt[k] + 1 > STARVE) ? STARVE : wcnt[k] + 1;
                else wcnt[k] = 0;
            end
        end
        cyc++;
    endtask

    task automatic stepExpect(input string name, input logic rstV, input logic [2:0] req,
                              input logic rdy, input logic [2:0] expGnt, input logic [2:0] expRv);
        applyStimulus(rstV, req, rdy, AW'($urandom), AW'($urandom), AW'($urandom), $urandom);
        checkOutput({name, " gnt"}, 32'(obsGnt), 32'(expGnt));
        checkOutput({name, " rvalid"}, 32'(obsRv), 32'(expRv));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]    rq;
        logic [DW-1:0] rd;
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; c_req = 1'b0;
        i_addr = '0; d_addr = '0; c_addr = '0;
        m_rdy = 1'b1; m_rdata = '0;
        for (int k = 0; k < 3; k++) wcnt[k] = 0;
        lastAddr = '0;

        // {rst, req(c,d,i), rdy, expected gnt(c,d,i), expected rvalid(c,d,i)}
        vecs[0]  = '{1'b1, 3'b111, 1'b1, 3'b000, 3'b000};
        vecs[1]  = '{1'b1, 3'b111, 1'b1, 3'b000, 3'b000};
        vecs[2]  = '{1'b1, 3'b111, 1'b1, 3'b000, 3'b000};
        vecs[3]  = '{1'b0, 3'b111, 1'b1, 3'b001, 3'b000};
        vecs[4]  = '{1'b0, 3'b110, 1'b1, 3'b010, 3'b000};
        vecs[5]  = '{1'b0, 3'b100, 1'b1, 3'b100, 3'b001};
        vecs[6]  = '{1'b0, 3'b000, 1'b1, 3'b000, 3'b010};
        vecs[7]  = '{1'b0, 3'b000, 1'b1, 3'b000, 3'b100};
        vecs[8]  = '{1'b0, 3'b000, 1'b1, 3'b000, 3'b000};
        vecs[9]  = '{1'b0, 3'b010, 1'b0, 3'b000, 3'b000};
        vecs[10] = '{1'b0, 3'b000, 1'b1, 3'b000, 3'b000};
        vecs[11] = '{1'b0, 3'b000, 1'b1, 3'b000, 3'b000};
        vecs[12] = '{1'b0, 3'b000, 1'b1, 3'b000, 3'b000};

        $display("[TB] vector table");
        for (int v = 0; v < 13; v++) begin
            stepExpect($sformatf("vec%0d", v), vecs[v].rst, vecs[v].req, vecs[v].rdy,
                       vecs[v].gnt, vecs[v].rv);
        end

        $display("[TB] single read");
        rd = 32'hCAFE_F00D;
        applyStimulus(1'b0, 3'b001, 1'b1, 15'h1234, AW'($urandom), AW'($urandom), $urandom);
        checkOutput("single m_addr", 32'(m_addr), 32'h1234);
        checkOutput("single m_en", 32'(m_en), 32'd1);
        stepExpect("single wait", 1'b0, 3'b000, 1'b1, 3'b000, 3'b000);
        applyStimulus(1'b0, 3'b000, 1'b1, AW'($urandom), AW'($urandom), AW'($urandom), rd);
        checkOutput("single i_rvalid", 32'(i_rvalid), 32'd1);
        checkOutput("single o_rdata", o_rdata, 32'hCAFE_F00D);
        stepExpect("single done", 1'b0, 3'b000, 1'b1, 3'b000, 3'b000);

        $display("[TB] starvation");
        stepExpect("starve s0", 1'b0, 3'b011, 1'b1, 3'b001, 3'b000);
        stepExpect("starve s1", 1'b0, 3'b011, 1'b1, 3'b001, 3'b000);
        stepExpect("starve s2", 1'b0, 3'b011, 1'b1, 3'b001, 3'b001);
        stepExpect("starve s3", 1'b0, 3'b011, 1'b1, 3'b001, 3'b001);
        stepExpect("starve s4", 1'b0, 3'b011, 1'b1, 3'b010, 3'b001);
        stepExpect("starve s5", 1'b0, 3'b011, 1'b1, 3'b001, 3'b001);
        stepExpect("starve s6", 1'b0, 3'b011, 1'b1, 3'b001, 3'b010);
        stepExpect("starve s7", 1'b0, 3'b000, 1'b1, 3'b000, 3'b001);
        stepExpect("starve s8", 1'b0, 3'b000, 1'b1, 3'b000, 3'b001);
        stepExpect("starve s9", 1'b0, 3'b000, 1'b1, 3'b000, 3'b000);

        $display("[TB] backpressure");
        stepExpect("bp b0", 1'b0, 3'b001, 1'b1, 3'b001, 3'b000);
        stepExpect("bp b1", 1'b0, 3'b010, 1'b0, 3'b000, 3'b000);
        stepExpect("bp b2", 1'b0, 3'b010, 1'b0, 3'b000, 3'b001);
        stepExpect("bp b3", 1'b0, 3'b010, 1'b0, 3'b000, 3'b000);
        stepExpect("bp b4", 1'b0, 3'b010, 1'b0, 3'b000, 3'b000);
        stepExpect("bp b5", 1'b0, 3'b010, 1'b0, 3'b000, 3'b000);
        checkOutput("bp m_en low", 32'(m_en), 32'd0);
        stepExpect("bp b6", 1'b0, 3'b011, 1'b1, 3'b010, 3'b000);
        stepExpect("bp b7", 1'b0, 3'b000, 1'b1, 3'b000, 3'b000);
        stepExpect("bp b8", 1'b0, 3'b000, 1'b1, 3'b000, 3'b010);
        stepExpect("bp b9", 1'b0, 3'b000, 1'b1, 3'b000, 3'b000);

        $display("[TB] reset mid-flight");
        stepExpect("rmf r0", 1'b0, 3'b100, 1'b1, 3'b100, 3'b000);
        stepExpect("rmf r1", 1'b1, 3'b000, 1'b1, 3'b000, 3'b000);
        stepExpect("rmf r2", 1'b0, 3'b000, 1'b1, 3'b000, 3'b000);
        stepExpect("rmf r3", 1'b0, 3'b000, 1'b1, 3'b000, 3'b000);

        $display("[TB] randomized traffic");
        rq = 3'b000;
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 3) == 0) rq[k] = ~rq[k];
            end
            applyStimulus(($urandom_range(0, 49) == 0), rq, ($urandom_range(0, 4) != 0),
                          AW'($urandom), AW'($urandom), AW'($urandom), $urandom);
        end
        for (int n = 0; n < RDLAT + 1; n++) begin
            applyStimulus(1'b0, 3'b000, 1'b1, AW'($urandom), AW'($urandom), AW'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
